i2c_target_regif: RTL and testbench



---
 rtl/i2c_target_regif.sv | 224 ++++++++++++++++++++++
 tb/tb_i2c_target_regif.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_target_regif.sv
// I2C target with a register-file port: START/STOP decode, 7-bit address match, index auto-increment.
// Defining I2C_TARGET_GLITCH_FILTER_EN inserts a FILTER_LEN-sample glitch filter after the synchronizers.
module i2c_target_regif #(
    parameter logic [6:0] TARGET_ADDR = 7'h50,
    parameter int         SYNC_STAGES = 2,
    parameter int         FILTER_LEN  = 3
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       SCL_IN,
    input  logic       SDA_IN,
    output logic       SDA_OE,
    output logic       reg_wr_en,
    output logic [7:0] reg_wr_index,
    output logic [7:0] reg_wr_data,
    output logic [7:0] reg_rd_index,
    input  logic [7:0] reg_rd_data,
    output logic       busy,
    output logic       start_det,
    output logic       stop_det
);
    typedef enum logic [3:0] {
        IDLE, ADDR, ADDR_ACK, INDEX, INDEX_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, IGNORE
    } state_t;

    logic [1:0] line_in;
    logic [1:0] line_f;
    logic [1:0] line_q_reg;

    // Bit 1 carries SCL, bit 0 carries SDA.
    assign line_in = {SCL_IN, SDA_IN};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_line
            logic [SYNC_STAGES-1:0] sync_reg;
            always_ff @(posedge CLK) begin
                if (RST) sync_reg <= '1;
                else     sync_reg <= {sync_reg[SYNC_STAGES-2:0], line_in[gi]};
            end
`ifdef I2C_TARGET_GLITCH_FILTER_EN
            localparam int CW = $clog2(FILTER_LEN + 1);
            logic          filt_reg;
            logic [CW-1:0] cnt_reg;
            always_ff @(posedge CLK) begin
                if (RST) begin
                    filt_reg <= 1'b1;
                    cnt_reg  <= '0;
                end else if (sync_reg[SYNC_STAGES-1] == filt_reg) begin
                    cnt_reg <= '0;
                end else if (cnt_reg == CW'(FILTER_LEN - 1)) begin
                    filt_reg <= sync_reg[SYNC_STAGES-1];
                    cnt_reg  <= '0;
                end else begin
                    cnt_reg <= cnt_reg + 1'b1;
                end
            end
            assign line_f[gi] = filt_reg;
`else
            assign line_f[gi] = sync_reg[SYNC_STAGES-1];
`endif
        end
    endgenerate

    always_ff @(posedge CLK) begin
        if (RST) line_q_reg <= 2'b11;
        else     line_q_reg <= line_f;
    end

    logic scl, sda, scl_q, sda_q;
    logic scl_rise, scl_fall, start_cond, stop_cond;
    assign scl        = line_f[1];
    assign sda        = line_f[0];
    assign scl_q      = line_q_reg[1];
    assign sda_q      = line_q_reg[0];
    assign scl_rise   = scl & ~scl_q;
    assign scl_fall   = ~scl & scl_q;
    // SCL level before any coincident edge qualifies START/STOP.
    assign start_cond = ~sda & sda_q & scl_q;
    assign stop_cond  = sda & ~sda_q & scl_q;

    state_t     state_reg, state_next;
    logic [7:0] shift_reg, shift_next;
    logic [2:0] bit_cnt_reg, bit_cnt_next;
    logic [7:0] ptr_reg, ptr_next;
    logic       ack_on_reg, ack_on_next;
    logic       sda_oe_reg, sda_oe_next;
    logic       wr_en_reg, wr_en_next;
    logic [7:0] wr_index_reg, wr_index_next;
    logic [7:0] wr_data_reg, wr_data_next;
    logic       start_det_reg, stop_det_reg;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_reg     <= IDLE;
            shift_reg     <= '0;
            bit_cnt_reg   <= '0;
            ptr_reg       <= '0;
            ack_on_reg    <= 1'b0;
            sda_oe_reg    <= 1'b0;
            wr_en_reg     <= 1'b0;
            wr_index_reg  <= '0;
            wr_data_reg   <= '0;
            start_det_reg <= 1'b0;
            stop_det_reg  <= 1'b0;
        end else begin
            state_reg     <= state_next;
            shift_reg     <= shift_next;
            bit_cnt_reg   <= bit_cnt_next;
            ptr_reg       <= ptr_next;
            ack_on_reg    <= ack_on_next;
            sda_oe_reg    <= sda_oe_next;
            wr_en_reg     <= wr_en_next;
            wr_index_reg  <= wr_index_next;
            wr_data_reg   <= wr_data_next;
            start_det_reg <= start_cond;
            stop_det_reg  <= stop_cond;
        end
    end

    always_comb begin
        state_next = state_reg;
        if (start_cond) begin
            state_next = ADDR;
        end else if (stop_cond) begin
            state_next = IDLE;
        end else begin
            case (state_reg)
                ADDR:      if (scl_rise && bit_cnt_reg == 3'd7)
                               state_next = (shift_reg[6:0] == TARGET_ADDR) ? ADDR_ACK : IGNORE;
                ADDR_ACK:  if (scl_fall && ack_on_reg) state_next = shift_reg[0] ? RDATA : INDEX;
                INDEX:     if (scl_rise && bit_cnt_reg == 3'd7) state_next = INDEX_ACK;
                INDEX_ACK: if (scl_fall && ack_on_reg) state_next = WDATA;
                WDATA:     if (scl_rise && bit_cnt_reg == 3'd7) state_next = WDATA_ACK;
                WDATA_ACK: if (scl_fall && ack_on_reg) state_next = WDATA;
                RDATA:     if (scl_fall && bit_cnt_reg == 3'd7) state_next = RDATA_ACK;
                RDATA_ACK: begin
                    if (scl_rise && sda)              state_next = IGNORE;
                    else if (scl_fall && ack_on_reg)  state_next = RDATA;
                end
                default:   state_next = state_reg;
            endcase
        end
    end

    // ACK states use ack_on_reg to tell the ACK-start fall from the ACK-end fall.
    always_comb begin
        shift_next    = shift_reg;
        bit_cnt_next  = bit_cnt_reg;
        ptr_next      = ptr_reg;
        ack_on_next   = ack_on_reg;
        sda_oe_next   = sda_oe_reg;
        wr_en_next    = 1'b0;
        wr_index_next = wr_index_reg;
        wr_data_next  = wr_data_reg;
        if (start_cond || stop_cond) begin
            bit_cnt_next = '0;
            ack_on_next  = 1'b0;
            sda_oe_next  = 1'b0;
        end else begin
            case (state_reg)
                ADDR, INDEX, WDATA: if (scl_rise) begin
                    shift_next   = {shift_reg[6:0], sda};
                    bit_cnt_next = bit_cnt_reg + 3'd1;
                end
                ADDR_ACK, INDEX_ACK, WDATA_ACK: if (scl_fall) begin
                    if (!ack_on_reg) begin
                        ack_on_next = 1'b1;
                        sda_oe_next = 1'b1;
                        if (state_reg == INDEX_ACK) ptr_next = shift_reg;
                        if (state_reg == WDATA_ACK) begin
                            wr_en_next    = 1'b1;
                            wr_index_next = ptr_reg;
                            wr_data_next  = shift_reg;
                            ptr_next      = ptr_reg + 8'd1;
                        end
                    end else begin
                        ack_on_next = 1'b0;
                        sda_oe_next = 1'b0;
                        if (state_reg == ADDR_ACK && shift_reg[0]) begin
                            shift_next   = reg_rd_data;
                            ptr_next     = ptr_reg + 8'd1;
                            sda_oe_next  = ~reg_rd_data[7];
                            bit_cnt_next = '0;
                        end
                    end
                end
                RDATA: if (scl_fall) begin
                    if (bit_cnt_reg == 3'd7) begin
                        sda_oe_next  = 1'b0;
                        bit_cnt_next = '0;
                    end else begin
                        shift_next   = {shift_reg[6:0], 1'b0};
                        sda_oe_next  = ~shift_reg[6];
                        bit_cnt_next = bit_cnt_reg + 3'd1;
                    end
                end
                RDATA_ACK: begin
                    if (scl_rise && !sda) begin
                        ack_on_next = 1'b1;
                    end else if (scl_fall && ack_on_reg) begin
                        ack_on_next  = 1'b0;
                        shift_next   = reg_rd_data;
                        ptr_next     = ptr_reg + 8'd1;
                        sda_oe_next  = ~reg_rd_data[7];
                        bit_cnt_next = '0;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        SDA_OE       = sda_oe_reg;
        reg_wr_en    = wr_en_reg;
        reg_wr_index = wr_index_reg;
        reg_wr_data  = wr_data_reg;
        reg_rd_index = ptr_reg;
        busy         = (state_reg != IDLE);
        start_det    = start_det_reg;
        stop_det     = stop_det_reg;
    end
endmodule

// File: tb/tb_i2c_target_regif.sv
// Directed bench for i2c_target_regif: byte-level vector table driven through a small I2C master model.
module tb_i2c_target_regif;
    localparam int Q = 10;
    localparam int OP_START = 0, OP_STOP = 1, OP_WR = 2, OP_RD = 3, OP_BUSY = 4, OP_OE0 = 5;

    typedef struct {
        int         op;
        logic [7:0] data;
        logic       ack;
        logic       wr;
        logic [7:0] wi;
        logic [7:0] wd;
    } vec_t;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       scl_m = 1'b1;
    logic       sda_m = 1'b1;
    logic       SDA_IN;
    logic       SDA_OE;
    logic       reg_wr_en;
    logic [7:0] reg_wr_index;
    logic [7:0] reg_wr_data;
    logic [7:0] reg_rd_index;
    logic [7:0] reg_rd_data;
    logic       busy;
    logic       start_det;
    logic       stop_det;

    int         checks = 0;
    int         failures = 0;
    int         wr_cnt = 0;
    int         start_cnt = 0;
    int         stop_cnt = 0;
    int         oe_cnt = 0;
    int         oe_mark = 0;
    logic [7:0] last_wi = 8'h00;
    logic [7:0] last_wd = 8'h00;
    logic [7:0] regs [256];
    vec_t       vecs [$];

    always #5 CLK = ~CLK;

    assign SDA_IN      = sda_m & ~SDA_OE;
    assign reg_rd_data = regs[reg_rd_index];

    i2c_target_regif dut (
        .CLK(CLK), .RST(RST), .SCL_IN(scl_m), .SDA_IN(SDA_IN), .SDA_OE(SDA_OE),
        .reg_wr_en(reg_wr_en), .reg_wr_index(reg_wr_index), .reg_wr_data(reg_wr_data),
        .reg_rd_index(reg_rd_index), .reg_rd_data(reg_rd_data), .busy(busy),
        .start_det(start_det), .stop_det(stop_det)
    );

    // Register-file model and event counters.
    initial begin
        for (int i = 0; i < 256; i++) regs[i] = 8'hFF;
        regs[8'h12] = 8'h7E;
        regs[8'h30] = 8'h00;
        forever begin
            @(negedge CLK);
            if (reg_wr_en) begin
                regs[reg_wr_index] = reg_wr_data;
                last_wi = reg_wr_index;
                last_wd = reg_wr_data;
                wr_cnt++;
            end
            if (start_det) start_cnt++;
            if (stop_det)  stop_cnt++;
            if (SDA_OE)    oe_cnt++;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    task automatic wq();
        repeat (Q) @(negedge CLK);
    endtask

    task automatic clk_bit(input logic b, output logic r);
        sda_m = b;
        wq();
        scl_m = 1'b1;
        wq();
        r = SDA_IN;
        wq();
        scl_m = 1'b0;
        wq();
    endtask

    task automatic do_start();
        int s0;
        s0 = start_cnt;
        sda_m = 1'b1; wq();
        scl_m = 1'b1; wq();
        sda_m = 1'b0; wq();
        scl_m = 1'b0; wq();
        check("start_det", start_cnt - s0, 1);
        oe_mark = oe_cnt;
        $display("txn START");
    endtask

    task automatic do_stop();
        int s0;
        s0 = stop_cnt;
        sda_m = 1'b0; wq();
        scl_m = 1'b1; wq();
        sda_m = 1'b1; wq(); wq();
        check("stop_det", stop_cnt - s0, 1);
        $display("txn STOP");
    endtask

    task automatic do_wr(input logic [7:0] d, input logic exp_ack, input logic chk,
                         input logic [7:0] wi, input logic [7:0] wd);
        int   w0;
        logic r, a;
        w0 = wr_cnt;
        for (int i = 7; i >= 0; i--) clk_bit(d[i], r);
        clk_bit(1'b1, a);
        check("ack_bit", a, exp_ack);
        check("wr_strobes", wr_cnt - w0, chk);
        if (chk) begin
            check("wr_index", last_wi, wi);
            check("wr_data", last_wd, wd);
        end
        $display("txn WR data=%02h ack=%0b writes=%0d", d, a, wr_cnt - w0);
    endtask

    task automatic do_rd(input logic [7:0] exp, input logic mack);
        int         w0;
        logic       r;
        logic [7:0] got;
        w0 = wr_cnt;
        for (int i = 7; i >= 0; i--) begin
            clk_bit(1'b1, r);
            got[i] = r;
        end
        clk_bit(mack, r);
        check("rd_byte", got, exp);
        check("rd_no_write", wr_cnt - w0, 0);
        if (mack) check("sda_released_nack", SDA_OE, 1'b0);
        $display("txn RD data=%02h master_ack=%0b", got, mack);
    endtask

    function automatic void add(input int op, input logic [7:0] d, input logic a,
                                input logic w, input logic [7:0] wi, input logic [7:0] wd);
        vecs.push_back('{op, d, a, w, wi, wd});
    endfunction

    initial begin
        int   s0, p0, g_exp;
        logic r;

        // Plain write: index 0x10, data A5, 3C.
        add(OP_START, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
        add(OP_WR,    8'hA0, 1'b0, 1'b0, 8'h00, 8'h00);
        add(OP_WR,    8'h10, 1'b0, 1'b0, 8'h00, 8'h00);
        add(OP_WR,    8'hA5, 1'b0, 1'b1, 8'h10, 8'hA5);
        add(OP_WR,    8'h3C, 1'b0, 1'b1, 8'h11, 8'h3C);
        add(OP_STOP,  8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
        add(OP_BUSY,  8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
        // Index write, repeated START, 3-byte read ending in NACK.
        add(OP_START, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
        add(OP_WR,    8'hA0, 1'b0, 1'b0, 8'h00, 8'h00);
        add(OP_WR,    8'h10, 1'b0, 1'b0, 8'h00, 8'h00);
        add(OP_START, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
        add(OP_WR,    8'hA1, 1'b0, 1'b0, 8'h00, 8'h00);
        add(OP_RD,    8'hA5, 1'b0, 1'b0, 8'h00, 8'h00);
        add(OP_RD,    8'h3C, 1'b0, 1'b0, 8'h00, 8'h00);
        add(OP_RD,    8'h7E, 1'b1, 1'b0, 8'h00, 8'h00);
        add(OP_BUSY,  8'h00, 1'b1, 1'b0, 8'h00, 8'h00);
        add(OP_STOP,  8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
        add(OP_BUSY,  8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
        // Address 0x51: no ACK, no writes, no SDA drive until STOP.
        add(OP_START, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
        add(OP_WR,    8'hA2, 1'b1, 1'b0, 8'h00, 8'h00);
        add(OP_BUSY,  8'h00, 1'b1, 1'b0, 8'h00, 8'h00);
        add(OP_WR,    8'h10, 1'b1, 1'b0, 8'h00, 8'h00);
        add(OP_WR,    8'h55, 1'b1, 1'b0, 8'h00, 8'h00);
        add(OP_OE0,   8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
        add(OP_BUSY,  8'h00, 1'b1, 1'b0, 8'h00, 8'h00);
        add(OP_STOP,  8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
        add(OP_BUSY,  8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
        // Pointer wrap 0xFF -> 0x00.
        add(OP_START, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
        add(OP_WR,    8'hA0, 1'b0, 1'b0, 8'h00, 8'h00);
        add(OP_WR,    8'hFF, 1'b0, 1'b0, 8'h00, 8'h00);
        add(OP_WR,    8'h11, 1'b0, 1'b1, 8'hFF, 8'h11);
        add(OP_WR,    8'h22, 1'b0, 1'b1, 8'h00, 8'h22);
        add(OP_STOP,  8'h00, 1'b0, 1'b0, 8'h00, 8'h00);

        repeat (4) @(negedge CLK);
        check("rst_sda_oe", SDA_OE, 1'b0);
        check("rst_wr_en", reg_wr_en, 1'b0);
        check("rst_wr_index", reg_wr_index, 8'h00);
        check("rst_wr_data", reg_wr_data, 8'h00);
        check("rst_rd_index", reg_rd_index, 8'h00);
        check("rst_busy", busy, 1'b0);
        check("rst_start_det", start_det, 1'b0);
        check("rst_stop_det", stop_det, 1'b0);
        RST = 1'b0;
        repeat (5) @(negedge CLK);

        for (int k = 0; k < vecs.size(); k++) begin
            case (vecs[k].op)
                OP_START: do_start();
                OP_STOP:  do_stop();
                OP_WR:    do_wr(vecs[k].data, vecs[k].ack, vecs[k].wr, vecs[k].wi, vecs[k].wd);
                OP_RD:    do_rd(vecs[k].data, vecs[k].ack);
                OP_BUSY: begin
                    check("busy", busy, vecs[k].ack);
                    $display("txn BUSY busy=%0b", busy);
                end
                OP_OE0: begin
                    check("sda_oe_never", oe_cnt - oe_mark, 0);
                    $display("txn OE_IDLE cycles=%0d", oe_cnt - oe_mark);
                end
                default: ;
            endcase
        end

        // Reset in the middle of the 4th bit of a read byte (regs[0x30]=0 keeps SDA pulled low).
        do_start();
        do_wr(8'hA0, 1'b0, 1'b0, 8'h00, 8'h00);
        do_wr(8'h30, 1'b0, 1'b0, 8'h00, 8'h00);
        do_start();
        do_wr(8'hA1, 1'b0, 1'b0, 8'h00, 8'h00);
        for (int i = 0; i < 3; i++) clk_bit(1'b1, r);
        sda_m = 1'b1; wq();
        scl_m = 1'b1; wq();
        check("rd_bit4_driven", SDA_OE, 1'b1);
        RST = 1'b1;
        @(negedge CLK);
        check("midrst_sda_oe", SDA_OE, 1'b0);
        check("midrst_busy", busy, 1'b0);
        RST = 1'b0;
        $display("txn RESET mid-read");
        wq();
        scl_m = 1'b0; wq();
        do_start();
        do_wr(8'hA0, 1'b0, 1'b0, 8'h00, 8'h00);
        do_wr(8'h40, 1'b0, 1'b0, 8'h00, 8'h00);
        do_wr(8'h99, 1'b0, 1'b1, 8'h40, 8'h99);
        do_stop();

        // Two-cycle SDA low pulse while SCL is high.
`ifdef I2C_TARGET_GLITCH_FILTER_EN
        g_exp = 0;
`else
        g_exp = 1;
`endif
        s0 = start_cnt;
        p0 = stop_cnt;
        @(negedge CLK);
        sda_m = 1'b0;
        repeat (2) @(negedge CLK);
        sda_m = 1'b1;
        repeat (20) @(negedge CLK);
        check("glitch_start", start_cnt - s0, g_exp);
        check("glitch_stop", stop_cnt - p0, g_exp);
        check("glitch_busy", busy, 1'b0);
        $display("txn GLITCH starts=%0d stops=%0d", start_cnt - s0, stop_cnt - p0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
